// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter onto a single-cycle memory port.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_we,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  // Handshake: a requester holds req (and its address/data) until it sees gnt in the same
  // cycle; the response follows exactly one cycle after gnt and cannot be stalled.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       store_q, store_d;
  logic       rst_hold_q;
  logic       gnt_ok;
  logic       fetch_first;

  // rst_hold_q keeps grants off for the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      store_q    <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      store_q    <= store_d;
      rst_hold_q <= 1'b0;
    end
  end

  assign gnt_ok      = rst & ~rst_hold_q;
  assign fetch_first = (starve_q == STARVE_LIM);
  assign i_gnt       = gnt_ok & i_req & (~d_req | fetch_first);
  assign d_gnt       = gnt_ok & d_req & ~(i_req & fetch_first);
  assign m_en        = i_gnt | d_gnt;

  always_comb begin
    m_addr  = '0;
    m_we    = 4'd0;
    m_wdata = 32'd0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = 4'd0;
    end else if (d_gnt && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d = IDLE;
    store_d = 1'b0;
    if (i_gnt) begin
      state_d = RESP_I;
    end else if (d_gnt) begin
      state_d = RESP_D;
      store_d = |d_we;
    end
  end

  // Gating with rst drops a response whose grant was in the cycle just before reset.
  assign i_rvalid = rst & (state_q == RESP_I);
  assign d_rvalid = rst & (state_q == RESP_D);
  assign i_rdata  = i_rvalid ? m_rdata : 32'd0;
  assign d_rdata  = (d_rvalid && !store_q) ? m_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-writable memory behind the port.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic [31:0] m_addr;
  logic [3:0]  m_we;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int n_checks;
  int n_errors;

  logic [31:0] mem [0:63];

  mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_addr   (m_addr),
    .m_we     (m_we),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data appears the cycle after m_en; writes merge enabled bytes.
  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hA000_0000 + k;
    m_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem[m_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (m_we[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_port(input string tag);
    check({tag, "_i_gnt"}, {31'd0, i_gnt}, 32'd0);
    check({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
    check({tag, "_m_en"},  {31'd0, m_en},  32'd0);
    check({tag, "_m_addr"}, m_addr, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst     = 1'b0;
    i_req   = 1'b1;
    i_addr  = 32'h4;
    d_req   = 1'b1;
    d_addr  = 32'h8;
    d_we    = 4'hF;
    d_wdata = 32'h1234_5678;

    // Reset with both requests high: everything must stay quiet.
    sample();
    check_idle_port("rst0");
    check("rst0_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rst0_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rst0_m_we", {28'd0, m_we}, 32'd0);
    check("rst0_m_wdata", m_wdata, 32'd0);
    next_cycle();
    sample();
    check_idle_port("rst1");

    // First cycle after release: still no grant.
    next_cycle();
    rst = 1'b1; d_req = 1'b0; d_we = 4'd0; d_wdata = 32'd0;
    i_req = 1'b1; i_addr = 32'h0;
    sample();
    check_idle_port("post_rst");
    check("post_rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);

    // Fetch stream 0x00, 0x04, 0x08.
    next_cycle();
    sample();
    check("f0_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("f0_m_en", {31'd0, m_en}, 32'd1);
    check("f0_m_addr", m_addr, 32'h0);
    check("f0_m_we", {28'd0, m_we}, 32'd0);
    check("f0_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    next_cycle(); i_addr = 32'h4;
    sample();
    check("f1_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("f1_m_addr", m_addr, 32'h4);
    check("f1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("f1_i_rdata", i_rdata, 32'hA000_0000);
    next_cycle(); i_addr = 32'h8;
    sample();
    check("f2_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("f2_i_rdata", i_rdata, 32'hA000_0001);
    next_cycle(); i_req = 1'b0;
    sample();
    check_idle_port("f3");
    check("f3_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("f3_i_rdata", i_rdata, 32'hA000_0002);

    // Simultaneous requests: data first, fetch next.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_addr = 32'h0C; d_we = 4'd0;
    sample();
    check("both_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("both_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("both_m_addr", m_addr, 32'h0C);
    check("both_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("both_i_rdata", i_rdata, 32'd0);
    next_cycle(); d_req = 1'b0;
    sample();
    check("both1_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("both1_m_addr", m_addr, 32'h20);
    check("both1_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("both1_d_rdata", d_rdata, 32'hA000_0003);
    next_cycle(); i_req = 1'b0;
    sample();
    check("both2_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("both2_i_rdata", i_rdata, 32'hA000_0008);
    check("both2_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("both2_d_rdata", d_rdata, 32'd0);

    // Halfword store then read-back.
    next_cycle();
    d_req = 1'b1; d_addr = 32'h10; d_we = 4'b0011; d_wdata = 32'hDEAD_BEEF;
    sample();
    check("st_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("st_m_we", {28'd0, m_we}, 32'h3);
    check("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    check("st_m_addr", m_addr, 32'h10);
    next_cycle(); d_req = 1'b0; d_we = 4'd0; d_wdata = 32'd0;
    sample();
    check("st_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("st_d_rdata", d_rdata, 32'd0);
    next_cycle(); d_req = 1'b1;
    sample();
    check("ld_d_gnt", {31'd0, d_gnt}, 32'd1);
    check("ld_m_we", {28'd0, m_we}, 32'd0);
    check("ld_m_wdata", m_wdata, 32'd0);
    next_cycle(); d_req = 1'b0;
    sample();
    check("ld_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check("ld_d_rdata", d_rdata, 32'hA000_BEEF);

    // Both held continuously: D,D,D,D,I repeating.
    next_cycle();
    i_req = 1'b1; i_addr = 32'h14;
    d_req = 1'b1; d_addr = 32'h18;
    for (int i = 0; i < 10; i++) begin
      sample();
      check($sformatf("starve%0d_d_gnt", i), {31'd0, d_gnt}, {31'd0, (i % 5) != 4});
      check($sformatf("starve%0d_i_gnt", i), {31'd0, i_gnt}, {31'd0, (i % 5) == 4});
      check($sformatf("starve%0d_m_en", i), {31'd0, m_en}, 32'd1);
      next_cycle();
    end

    // Reset right after a fetch grant: the response is dropped.
    d_req = 1'b0; i_addr = 32'h4;
    sample();
    check("rg_i_gnt", {31'd0, i_gnt}, 32'd1);
    next_cycle(); rst = 1'b0; i_req = 1'b0;
    sample();
    check("rg_rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    check("rg_rst_i_rdata", i_rdata, 32'd0);
    check_idle_port("rg_rst");
    next_cycle(); rst = 1'b1; i_req = 1'b1; i_addr = 32'h8;
    sample();
    check("rg_post_i_gnt", {31'd0, i_gnt}, 32'd0);
    check("rg_post_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    next_cycle();
    sample();
    check("rg_new_i_gnt", {31'd0, i_gnt}, 32'd1);
    check("rg_new_m_addr", m_addr, 32'h8);
    check("rg_new_i_rvalid", {31'd0, i_rvalid}, 32'd0);
    next_cycle(); i_req = 1'b0;
    sample();
    check("rg_resp_i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("rg_resp_i_rdata", i_rdata, 32'hA000_0002);
    next_cycle();
    sample();
    check("rg_end_i_rvalid", {31'd0, i_rvalid}, 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
